regfile_bypass: RTL and testbench

Parametrised decode-stage register file with a same-cycle write-to-read bypass, registered read outputs that hold on stall and clear on flush, and a pending-load scoreboard that raises a hazard for load-use dependencies. It replaces the negative-edge-write register file and the per-field read-data latches in the decode stage. Writeback from the memory stage drives the write port. Fetch-stage instruction fields drive the read addresses. The execute stage consumes the registered read data.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_bypass_if.sv | 33 +++
 rtl/sb_tracker.sv | 60 ++++++
 rtl/regfile_bypass.sv | 90 +++++++++
 tb/tb_regfile_bypass.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the decode-stage register file.
package regfile_pkg;

    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_NREGS = 32;
    localparam int unsigned DEF_NRD   = 2;

    // Address width for a given register count (at least one bit).
    function automatic int unsigned aw_for(input int unsigned nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// Decode-stage register file bus: writeback write port, fetch read
// addresses, execute read data and the load scoreboard controls.
interface regfile_bypass_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned NRD   = DEF_NRD
) ();
    localparam int unsigned AW = aw_for(NREGS);

    logic                 stall;
    logic                 flush;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [WIDTH-1:0]     wd;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd_q;
    logic                 sb_set;
    logic [AW-1:0]        sb_addr;
    logic                 hazard;

    modport master (
        output stall, flush, we, wa, wd, ra, sb_set, sb_addr,
        input  rd_q, hazard
    );

    modport slave (
        input  stall, flush, we, wa, wd, ra, sb_set, sb_addr,
        output rd_q, hazard
    );

endinterface

// File: rtl/sb_tracker.sv
// Pending-load scoreboard: one bit per register, set by an issuing load,
// cleared by the retiring write, and reduced into a load-use hazard.
module sb_tracker
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS    = DEF_NREGS,
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_set,
    input  logic [aw_for(NREGS)-1:0] i_set_addr,
    input  logic              i_clr,
    input  logic [aw_for(NREGS)-1:0] i_clr_addr,
    input  logic [NRD*aw_for(NREGS)-1:0] i_ra,
    output logic              o_hazard_c
);
    localparam int unsigned AW = aw_for(NREGS);

    logic [NREGS-1:0] r_sb;
    logic [NREGS-1:0] w_sb_nxt;

    // In-range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_REG && (a == AW'(REG_ZERO)));
    endfunction

    // Next scoreboard: clear first so a colliding set wins.
    always_comb begin
        w_sb_nxt = r_sb;
        if (i_clr && addr_ok(i_clr_addr)) begin
            w_sb_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set && addr_ok(i_set_addr)) begin
            w_sb_nxt[i_set_addr] = 1'b1;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_nxt;
        end
    end

    // Any port reading a pending register not being written this cycle.
    always_comb begin
        o_hazard_c = 1'b0;
        for (int i = 0; i < int'(NRD); i++) begin
            if (addr_ok(i_ra[i*AW +: AW]) && r_sb[i_ra[i*AW +: AW]]
                && !(i_clr && (i_clr_addr == i_ra[i*AW +: AW]))) begin
                o_hazard_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Decode-stage register file with same-cycle write-to-read bypass,
// registered read data (stall hold, flush clear) and load-use hazard.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NREGS    = DEF_NREGS,
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_bypass_if.slave bus
);
    localparam int unsigned AW = aw_for(NREGS);

    logic [WIDTH-1:0]     r_mem [NREGS];
    logic [NRD*WIDTH-1:0] r_rd_q;
    logic [WIDTH-1:0]     w_rd_val [NRD];
    logic [NRD*WIDTH-1:0] w_rd_pack;
    logic                 w_wr_en;
    logic                 w_hazard;

    // In-range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_REG && (a == AW'(REG_ZERO)));
    endfunction

    assign w_wr_en = bus.we && addr_ok(bus.wa);

    // Register array; writeback always retires regardless of stall/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    // Per-port read mux: zero/out-of-range, then bypass, then array.
    for (genvar gi = 0; gi < int'(NRD); gi++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_ra_ok;
        assign w_ra    = bus.ra[gi*AW +: AW];
        assign w_ra_ok = addr_ok(w_ra);
        assign w_rd_val[gi] = !w_ra_ok                        ? '0     :
                              (bus.we && (bus.wa == w_ra))    ? bus.wd :
                                                                r_mem[w_ra];
    end

    // Pack port values onto the flat read-data bus.
    always_comb begin
        w_rd_pack = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            w_rd_pack[i*WIDTH +: WIDTH] = w_rd_val[i];
        end
    end

    // Read-data register: flush over stall over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_q <= '0;
        end else if (bus.flush) begin
            r_rd_q <= '0;
        end else if (!bus.stall) begin
            r_rd_q <= w_rd_pack;
        end
    end

    sb_tracker #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set      (bus.sb_set),
        .i_set_addr (bus.sb_addr),
        .i_clr      (bus.we),
        .i_clr_addr (bus.wa),
        .i_ra       (bus.ra),
        .o_hazard_c (w_hazard)
    );

    assign bus.rd_q   = r_rd_q;
    assign bus.hazard = w_hazard;

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass: default, 16x16/3-port and
// 12-entry (non power of two) configurations.
module tb_regfile_bypass;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_fail;

    regfile_bypass_if #(.WIDTH(32), .NREGS(32), .NRD(2)) b0 ();
    regfile_bypass_if #(.WIDTH(16), .NREGS(16), .NRD(3)) b1 ();
    regfile_bypass_if #(.WIDTH(8),  .NREGS(12), .NRD(1)) b2 ();

    regfile_bypass #(.WIDTH(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (b0.slave)
    );
    regfile_bypass #(.WIDTH(16), .NREGS(16), .NRD(3), .ZERO_REG(1'b1)) u_sw (
        .clk (clk), .rst_n (rst_n), .bus (b1.slave)
    );
    regfile_bypass #(.WIDTH(8), .NREGS(12), .NRD(1), .ZERO_REG(1'b1)) u_or (
        .clk (clk), .rst_n (rst_n), .bus (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        sb_set;
        logic [4:0]  sb_addr;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ehz;
    } vec_t;

    vec_t        vt[$];
    logic [63:0] q0[$];
    logic [47:0] q1[$];
    logic [7:0]  q2[$];

    function automatic vec_t mk(input logic st, input logic fl, input logic we,
                                input int wa, input logic [31:0] wd,
                                input int ra0, input int ra1,
                                input logic sbs, input int sba,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic ehz);
        vec_t v;
        v.stall = st;  v.flush = fl;  v.we = we;
        v.wa = 5'(wa); v.wd = wd;
        v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
        v.sb_set = sbs; v.sb_addr = 5'(sba);
        v.e0 = e0; v.e1 = e1; v.ehz = ehz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        b0.stall = 0; b0.flush = 0; b0.we = 0; b0.wa = '0; b0.wd = '0;
        b0.ra = '0; b0.sb_set = 0; b0.sb_addr = '0;
        b1.stall = 0; b1.flush = 0; b1.we = 0; b1.wa = '0; b1.wd = '0;
        b1.ra = '0; b1.sb_set = 0; b1.sb_addr = '0;
        b2.stall = 0; b2.flush = 0; b2.we = 0; b2.wa = '0; b2.wd = '0;
        b2.ra = '0; b2.sb_set = 0; b2.sb_addr = '0;
    endtask

    function automatic logic [15:0] sw_val(input int i);
        if (i == 0) return 16'h0000;
        return 16'(i * 32'h1111) ^ 16'h0F0F;
    endfunction

    // One cycle on the non-power-of-two instance.
    task automatic or_cyc(input string nm, input logic we, input int wa,
                          input logic [7:0] wd, input int ra, input logic sbs,
                          input int sba, input logic [7:0] e, input logic ehz);
        logic [7:0] got;
        @(negedge clk);
        b2.we = we; b2.wa = 4'(wa); b2.wd = wd; b2.ra = 4'(ra);
        b2.sb_set = sbs; b2.sb_addr = 4'(sba);
        #1 chk({nm, "_hz"}, 64'(b2.hazard), 64'(ehz));
        q2.push_back(e);
        @(posedge clk);
        #1 got = q2.pop_front();
        chk({nm, "_rd"}, 64'(b2.rd_q), 64'(got));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got0;
        logic [47:0] got1;
        logic [47:0] e1;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_all();
        b0.ra = {5'd5, 5'd3};

        // Reset held two cycles.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_rd0", 64'(b0.rd_q), 64'h0);
        chk("reset_hz0", 64'(b0.hazard), 64'h0);
        chk("reset_rd1", 64'(b1.rd_q), 64'h0);
        chk("reset_rd2", 64'(b2.rd_q), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //          st fl we wa wd            ra0 ra1 sbs sba e0            e1            hz
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        3,  5,  0, 0, 32'h0,        32'h0,        0));
        vt.push_back(mk(0, 0, 1, 7, 32'hDEADBEEF, 7,  0,  0, 0, 32'hDEADBEEF, 32'h0,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        7,  7,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0));
        vt.push_back(mk(0, 0, 1, 0, 32'h12345678, 0,  7,  0, 0, 32'h0,        32'hDEADBEEF, 0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        0,  0,  0, 0, 32'h0,        32'h0,        0));
        vt.push_back(mk(0, 0, 1, 4, 32'h11,       1,  2,  0, 0, 32'h0,        32'h0,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        4,  4,  0, 0, 32'h11,       32'h11,       0));
        vt.push_back(mk(1, 0, 1, 4, 32'h22,       4,  7,  0, 0, 32'h11,       32'h11,       0));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        4,  7,  0, 0, 32'h11,       32'h11,       0));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        4,  7,  0, 0, 32'h11,       32'h11,       0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        4,  7,  0, 0, 32'h22,       32'hDEADBEEF, 0));
        vt.push_back(mk(1, 1, 0, 0, 32'h0,        4,  7,  0, 0, 32'h0,        32'h0,        0));
        vt.push_back(mk(0, 1, 1, 5, 32'hA5A5,     5,  5,  0, 0, 32'h0,        32'h0,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        5,  4,  0, 0, 32'hA5A5,     32'h22,       0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        0,  9,  1, 9, 32'h0,        32'h0,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        5,  9,  0, 0, 32'hA5A5,     32'h0,        1));
        vt.push_back(mk(1, 0, 0, 0, 32'h0,        9,  9,  0, 0, 32'hA5A5,     32'h0,        1));
        vt.push_back(mk(0, 0, 1, 9, 32'h55,       4,  9,  0, 0, 32'h22,       32'h55,       0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        0,  9,  0, 0, 32'h0,        32'h55,       0));
        vt.push_back(mk(0, 0, 1, 6, 32'h66,       6,  0,  1, 6, 32'h66,       32'h0,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        6,  0,  0, 0, 32'h66,       32'h0,        1));
        vt.push_back(mk(0, 0, 1, 6, 32'h67,       3,  6,  0, 0, 32'h0,        32'h67,       0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        0,  6,  0, 0, 32'h0,        32'h67,       0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        0,  0,  1, 0, 32'h0,        32'h0,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        0,  0,  0, 0, 32'h0,        32'h0,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        0,  0,  1, 12, 32'h0,       32'h0,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        12, 0,  0, 0, 32'h0,        32'h0,        1));
        vt.push_back(mk(0, 0, 1, 13, 32'h1,       12, 13, 0, 0, 32'h0,        32'h1,        1));
        vt.push_back(mk(0, 0, 1, 12, 32'hC,       12, 13, 0, 0, 32'hC,        32'h1,        0));
        vt.push_back(mk(0, 0, 0, 0, 32'h0,        12, 12, 0, 0, 32'hC,        32'hC,        0));

        // Table-driven cycles on the default instance.
        for (int k = 0; k < vt.size(); k++) begin
            @(negedge clk);
            b0.stall = vt[k].stall; b0.flush = vt[k].flush;
            b0.we = vt[k].we; b0.wa = vt[k].wa; b0.wd = vt[k].wd;
            b0.ra = {vt[k].ra1, vt[k].ra0};
            b0.sb_set = vt[k].sb_set; b0.sb_addr = vt[k].sb_addr;
            #1 chk($sformatf("v%0d_hz", k), 64'(b0.hazard), 64'(vt[k].ehz));
            q0.push_back({vt[k].e1, vt[k].e0});
            @(posedge clk);
            #1 got0 = q0.pop_front();
            chk($sformatf("v%0d_rd", k), 64'(b0.rd_q), got0);
        end

        // Reset in the middle of a pending load.
        @(negedge clk);
        idle_all();
        b0.sb_set = 1'b1; b0.sb_addr = 5'd20; b0.ra = {5'd0, 5'd4};
        @(posedge clk);
        #1 chk("pre_rst_rd", 64'(b0.rd_q), 64'h22);
        @(negedge clk);
        b0.sb_set = 1'b0; b0.ra = {5'd0, 5'd20};
        #1 chk("pre_rst_hz", 64'(b0.hazard), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", 64'(b0.rd_q), 64'h0);
        chk("mid_rst_hz", 64'(b0.hazard), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        b0.ra = {5'd7, 5'd20};
        #1 chk("post_rst_hz", 64'(b0.hazard), 64'h0);
        b0.ra = {5'd7, 5'd4};
        @(posedge clk);
        #1 chk("post_rst_rd", 64'(b0.rd_q), 64'h0);

        // Wide sweep: write all 16 registers.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle_all();
            b1.we = 1'b1; b1.wa = 4'(i); b1.wd = 16'(i * 32'h1111) ^ 16'h0F0F;
        end
        // Read back on three ports with different rotations.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle_all();
            b1.ra = {4'((i + 11) % 16), 4'((i + 5) % 16), 4'(i)};
            q1.push_back({sw_val((i + 11) % 16), sw_val((i + 5) % 16), sw_val(i)});
            @(posedge clk);
            #1 got1 = q1.pop_front();
            chk($sformatf("sw_rd%0d", i), 64'(b1.rd_q), 64'(got1));
        end
        // All three ports bypass one write together.
        @(negedge clk);
        b1.we = 1'b1; b1.wa = 4'd10; b1.wd = 16'hBEEF; b1.ra = {4'd10, 4'd10, 4'd10};
        e1 = {16'hBEEF, 16'hBEEF, 16'hBEEF};
        q1.push_back(e1);
        @(posedge clk);
        #1 got1 = q1.pop_front();
        chk("sw_bypass3", 64'(b1.rd_q), 64'(got1));
        @(negedge clk);
        b1.we = 1'b0; b1.ra = {4'd10, 4'd0, 4'd10};
        q1.push_back({16'hBEEF, 16'h0000, 16'hBEEF});
        @(posedge clk);
        #1 got1 = q1.pop_front();
        chk("sw_after", 64'(b1.rd_q), 64'(got1));
        @(negedge clk);
        idle_all();

        // Non-power-of-two entry count: out-of-range addresses.
        or_cyc("or_wr13",   1, 13, 8'hAA, 13, 0, 0,  8'h00, 0);
        or_cyc("or_byp11",  1, 11, 8'h5B, 11, 0, 0,  8'h5B, 0);
        or_cyc("or_set14",  0, 0,  8'h00, 11, 1, 14, 8'h5B, 0);
        or_cyc("or_rd14",   0, 0,  8'h00, 14, 0, 0,  8'h00, 0);
        or_cyc("or_set11",  0, 0,  8'h00, 11, 1, 11, 8'h5B, 0);
        or_cyc("or_hz11",   0, 0,  8'h00, 11, 0, 0,  8'h5B, 1);
        or_cyc("or_rd12",   0, 0,  8'h00, 12, 0, 0,  8'h00, 0);
        or_cyc("or_rd1",    0, 0,  8'h00, 1,  0, 0,  8'h00, 0);
        or_cyc("or_clr11",  1, 11, 8'h3C, 11, 0, 0,  8'h3C, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
